// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing
// constants and the parity helper also used by uart_tx.
package uart_pkg;

  localparam int unsigned OS_RATE_DEF   = 16;
  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Expected parity bit for a payload; narrower payloads are zero-extended
  // by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (both flops load 1)
//   i_async  asynchronous input
//   o_sync   synchronised output, 2 clk latency
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, false-start
// rejection, optional parity, framing/break detection and a one-entry
// holding register with valid/ack handshake.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   os_tick      strobe at baud*OS_RATE
//   rx_in        asynchronous serial line, idle high
//   rx_data      held payload (stable while rx_valid)
//   rx_valid     payload held, awaiting rx_ack
//   rx_ack       consumer accepts rx_data
//   parity_err   parity mismatch on held frame
//   frame_err    stop bit low on held frame
//   overrun      sticky: frame completed while rx_valid was set
//   rx_busy      receiver not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned OS_RATE    = OS_RATE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned OSW = $clog2(OS_RATE);
  localparam int unsigned MID = OS_RATE / 2;

  rx_state_t r_state, w_state_nxt;

  logic                 w_rxs;
  logic [OSW-1:0]       r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_flag;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr, r_ferr, r_overrun;

  logic w_tick_last, w_decide, w_vote, w_last_bit, w_commit;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_in),
    .o_sync  (w_rxs)
  );

  assign w_tick_last = os_tick && (r_os_cnt == OSW'(OS_RATE - 1));
  assign w_decide    = os_tick && (r_os_cnt == OSW'(MID + 1));
  // Third vote is the live sample taken at the decision tick itself.
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_last_bit  = (r_bit_cnt == 4'(DATA_BITS - 1));
  assign w_commit    = (r_state == STOP) && w_decide;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_rxs) w_state_nxt = START;
      START:   if (w_decide && w_vote) w_state_nxt = IDLE;
               else if (w_tick_last)   w_state_nxt = DATA;
      DATA:    if (w_tick_last && w_last_bit)
                 w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_tick_last) w_state_nxt = STOP;
      STOP:    if (w_decide) w_state_nxt = w_vote ? IDLE : BREAK;
      BREAK:   if (w_rxs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_flag <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_os_cnt   <= '0;
        r_bit_cnt  <= '0;
        r_par_flag <= 1'b0;
      end else if (os_tick) begin
        r_os_cnt <= w_tick_last ? '0 : r_os_cnt + 1'b1;
      end

      if (os_tick && r_os_cnt == OSW'(MID - 1)) r_s0 <= w_rxs;
      if (os_tick && r_os_cnt == OSW'(MID))     r_s1 <= w_rxs;

      if (r_state == DATA && w_decide)
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      if (r_state == DATA && w_tick_last)
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;

      if (r_state == PARITY && w_decide)
        r_par_flag <= w_vote ^ parity_bit(9'(r_shift), PARITY_ODD != 0);

      // Ack and commit are independent: an ack that coincides with a
      // commit still releases the held frame, but the new frame is lost.
      if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end
      if (w_commit) begin
        if (r_valid) begin
          r_overrun <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_perr  <= r_par_flag;
          r_ferr  <= ~w_vote;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic os_tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] data0, data1;
  logic valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

  int total = 0;
  int bad = 0;
  int unsigned tick_div = 1;
  int unsigned tick_ph = 0;

  // reference model for the default-configuration receiver
  bit       m_valid, m_ferr, m_ovr;
  bit [7:0] m_data;

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OS_RATE(16)) dut (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_in(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_ack(ack0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .rx_busy(busy0)
  );

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OS_RATE(16)) dut_p (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_in(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_ack(ack1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .rx_busy(busy1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_ph + 1 >= tick_div) begin
      tick_ph = 0;
      os_tick = 1'b1;
    end else begin
      tick_ph = tick_ph + 1;
      os_tick = 1'b0;
    end
  end

  task automatic drive_bit(input bit line, input logic v);
    if (line) rx1 = v; else rx0 = v;
    repeat (16 * tick_div) @(negedge clk);
  endtask

  task automatic send_head(input bit line, input logic [7:0] d, input bit par_en, input logic pb);
    drive_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
    if (par_en) drive_bit(line, pb);
  endtask

  task automatic send_frame(input bit line, input logic [7:0] d, input bit par_en, input logic pb);
    send_head(line, d, par_en, pb);
    drive_bit(line, 1'b1);
  endtask

  task automatic pulse_ack(input bit line);
    if (line) ack1 = 1'b1; else ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({valid0, perr0, ferr0, ovr0, busy0, data0, valid1, busy1} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b pe=%b fe=%b ov=%b busy=%b data=%h v1=%b busy1=%b required all 0",
               valid0, perr0, ferr0, ovr0, busy0, data0, valid1, busy1);
    end
  endtask

  task automatic test_basic;
    int n;
    send_head(1'b0, 8'hA5, 1'b0, 1'b0);
    rx0 = 1'b1;
    n = 0;
    while (!valid0 && n < 32) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (valid0 !== 1'b1) begin
      bad++; $display("FAIL basic_valid_timeout got valid=%b required 1 within 32 clk", valid0);
    end
    total++;
    if ({data0, perr0, ferr0, ovr0} !== {8'hA5, 3'b000}) begin
      bad++; $display("FAIL basic_data got data=%h pe=%b fe=%b ov=%b required A5 0 0 0", data0, perr0, ferr0, ovr0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (valid0 !== 1'b1) begin
      bad++; $display("FAIL basic_valid_hold got %b required 1", valid0);
    end
    pulse_ack(1'b0);
    total++;
    if (valid0 !== 1'b0) begin
      bad++; $display("FAIL basic_ack_clear got valid=%b required 0", valid0);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_parity;
    bit [7:0] d;
    bit       e;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
    total++;
    if ({valid1, data1, perr1, ferr1} !== {1'b1, 8'h3C, 2'b10}) begin
      bad++; $display("FAIL parity_wrong got v=%b data=%h pe=%b fe=%b required 1 3C 1 0", valid1, data1, perr1, ferr1);
    end
    pulse_ack(1'b1);
    total++;
    if ({valid1, perr1} !== 2'b00) begin
      bad++; $display("FAIL parity_ack_clear got v=%b pe=%b required 0 0", valid1, perr1);
    end
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      send_frame(1'b1, d, 1'b1, (^d) ^ e);
      total++;
      if ({valid1, data1, perr1, ferr1} !== {1'b1, d, e, 1'b0}) begin
        bad++; $display("FAIL parity_rand%0d got v=%b data=%h pe=%b fe=%b required 1 %h %b 0",
                        k, valid1, data1, perr1, ferr1, d, e);
      end
      pulse_ack(1'b1);
    end
  endtask

  task automatic test_glitch;
    bit saw_busy = 1'b0;
    bit saw_valid = 1'b0;
    rx0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_busy |= busy0;
      saw_valid |= valid0;
    end
    rx0 = 1'b1;
    repeat (9) begin
      @(negedge clk);
      saw_busy |= busy0;
      saw_valid |= valid0;
    end
    total++;
    if (saw_busy !== 1'b1) begin
      bad++; $display("FAIL glitch_busy_seen got %b required 1", saw_busy);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL glitch_busy_return got %b required 0 after 9 ticks", busy0);
    end
    repeat (32) begin
      @(negedge clk);
      saw_valid |= valid0;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++; $display("FAIL glitch_no_valid got %b required 0", saw_valid);
    end
  endtask

  task automatic test_break;
    send_head(1'b0, 8'h55, 1'b0, 1'b0);
    rx0 = 1'b0;
    repeat (48) @(negedge clk);
    total++;
    if ({valid0, data0, ferr0, perr0, busy0} !== {1'b1, 8'h55, 3'b101}) begin
      bad++; $display("FAIL break_frame got v=%b data=%h fe=%b pe=%b busy=%b required 1 55 1 0 1",
                      valid0, data0, ferr0, perr0, busy0);
    end
    rx0 = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL break_release got busy=%b required 0", busy0);
    end
    pulse_ack(1'b0);
    total++;
    if ({valid0, ferr0} !== 2'b00) begin
      bad++; $display("FAIL break_ack_clear got v=%b fe=%b required 0 0", valid0, ferr0);
    end
    repeat (16) @(negedge clk);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0);
    total++;
    if ({valid0, data0, ferr0} !== {1'b1, 8'h0F, 1'b0}) begin
      bad++; $display("FAIL break_next got v=%b data=%h fe=%b required 1 0F 0", valid0, data0, ferr0);
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_overrun;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0);
    total++;
    if ({valid0, data0, ovr0} !== {1'b1, 8'h11, 1'b0}) begin
      bad++; $display("FAIL ovr_first got v=%b data=%h ov=%b required 1 11 0", valid0, data0, ovr0);
    end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0);
    total++;
    if ({valid0, data0, ovr0} !== {1'b1, 8'h11, 1'b1}) begin
      bad++; $display("FAIL ovr_second got v=%b data=%h ov=%b required 1 11 1", valid0, data0, ovr0);
    end
    pulse_ack(1'b0);
    total++;
    if ({valid0, ovr0} !== 2'b01) begin
      bad++; $display("FAIL ovr_after_ack got v=%b ov=%b required 0 1", valid0, ovr0);
    end
    send_frame(1'b0, 8'h33, 1'b0, 1'b0);
    total++;
    if ({valid0, data0, ovr0} !== {1'b1, 8'h33, 1'b1}) begin
      bad++; $display("FAIL ovr_third got v=%b data=%h ov=%b required 1 33 1", valid0, data0, ovr0);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d = 8'h81;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i]);
    rx0 = d[3];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx0 = 1'b1;
    @(negedge clk);
    total++;
    if ({valid0, perr0, ferr0, ovr0, busy0, data0} !== 13'd0) begin
      bad++; $display("FAIL midrst_outputs got v=%b pe=%b fe=%b ov=%b busy=%b data=%h required all 0",
                      valid0, perr0, ferr0, ovr0, busy0, data0);
    end
    rst = 1'b0;
    repeat (16) @(negedge clk);
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0);
    total++;
    if ({valid0, data0, perr0, ferr0, ovr0} !== {1'b1, 8'h7E, 3'b000}) begin
      bad++; $display("FAIL midrst_next got v=%b data=%h pe=%b fe=%b ov=%b required 1 7E 0 0 0",
                      valid0, data0, perr0, ferr0, ovr0);
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_random;
    bit [7:0] d;
    bit       bad_stop;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_data = '0;
    for (int k = 0; k < 12; k++) begin
      tick_div = $urandom_range(1, 3);
      repeat (4) @(negedge clk);
      d = 8'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
      send_head(1'b0, d, 1'b0, 1'b0);
      if (bad_stop) drive_bit(1'b0, 1'b0);
      drive_bit(1'b0, 1'b1);
      if (!m_valid) begin
        m_valid = 1; m_data = d; m_ferr = bad_stop;
      end else begin
        m_ovr = 1;
      end
      total++;
      if ({valid0, data0, ferr0, ovr0} !== {m_valid, m_data, m_ferr, m_ovr}) begin
        bad++; $display("FAIL rand%0d got v=%b data=%h fe=%b ov=%b required %b %h %b %b (div=%0d)",
                        k, valid0, data0, ferr0, ovr0, m_valid, m_data, m_ferr, m_ovr, tick_div);
      end
      if ($urandom_range(0, 2) != 0) begin
        pulse_ack(1'b0);
        m_valid = 0; m_ferr = 0;
        total++;
        if ({valid0, ferr0} !== 2'b00) begin
          bad++; $display("FAIL rand%0d_ack got v=%b fe=%b required 0 0", k, valid0, ferr0);
        end
      end
    end
    tick_div = 1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_break;
    test_overrun;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: the receive end for the team's uart_tx serial stream.
- Adds over a simple receiver:
  - input synchronisation;
  - majority-vote bit sampling and false-start rejection;
  - optional parity;
  - framing/break detection;
  - one-entry output holding register with valid/ack handshake and overrun flag.
- Sits between the pad (or uart_tx loopback) and the consuming logic.
- Driven by an oversample tick from the baud generator, configured for baud*OS_RATE.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first, legal 5..9.
- PARITY_EN, 0: 1 = parity bit follows data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- OS_RATE, 16: os_tick pulses per bit period, even, >=8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- os_tick  in  1  single-cycle strobe at baud*OS_RATE.
- rx_in  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received payload, stable while rx_valid=1.
- rx_valid  out  1  payload held, awaiting ack.
- rx_ack  in  1  consumer accepts rx_data this cycle.
- parity_err  out  1  parity mismatch on the held frame.
- frame_err  out  1  stop bit sampled low on the held frame.
- overrun  out  1  sticky; a frame completed while rx_valid=1.
- rx_busy  out  1  receiver not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst=1 at a clk edge: FSM->IDLE, counters 0, synchroniser flops=1, rx_data=0, all flags and rx_valid=0.
  - Reset mid-frame abandons the frame; no partial data is delivered.
- Synchroniser:
  - 2 flops on rx_in; the FSM only sees the synchronised line, rxs.
  - Latency from rx_in to rxs is 2 clk.
- Sampling:
  - os counter 0..OS_RATE-1 advances only on os_tick.
  - Bit value = majority of rxs captured at counts OS_RATE/2-1, OS_RATE/2, OS_RATE/2+1.
  - Decision is made at count OS_RATE/2+1.
- States:
  - IDLE: rxs=0 on a clk edge -> START, os counter cleared.
  - START: at decision point, vote=1 (glitch) -> IDLE, no flags; vote=0 -> DATA after count wraps at OS_RATE-1.
  - DATA: shift the voted bit into the shift register MSB side after each bit (LSB first); after DATA_BITS bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: compare voted bit against the computed parity (XOR of data, inverted if PARITY_ODD); store the mismatch flag.
  - STOP: at decision point, commit the frame (see Commit); vote=1 -> IDLE; vote=0 -> BREAK.
  - BREAK: wait until rxs=1 on a clk edge -> IDLE. No new START is recognised while the line stays low.
- Commit (one clk at STOP decision point):
  - If rx_valid=0: rx_data<=shift register; parity_err, frame_err <= frame flags; rx_valid<=1.
  - If rx_valid=1 (including when rx_ack is asserted in the same cycle): held data retained, new frame dropped, overrun<=1.
- Handshake:
  - rx_ack while rx_valid=1 -> rx_valid<=0 next cycle.
  - The same rx_ack also clears parity_err and frame_err.
  - rx_ack while rx_valid=0 is ignored.
  - overrun clears only on rst.
- rx_busy: 1 in every state except IDLE.
- Frame-to-frame: the receiver returns to IDLE at the mid-stop decision, so a start edge immediately after a full stop bit is accepted.
- Errors never block reception; a frame with frame_err still commits its data.
- Tick/line relation: rxs is sampled only on os_tick cycles, except the IDLE start detect, which is evaluated every clk.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default OS_RATE and DATA_BITS constants;
  - a parity function (data, odd) -> bit, reused by uart_tx.
- One natural sub-module: uart_sync2, the 2-flop synchroniser with reset value 1, also reusable for other asynchronous inputs.

Test Plan:
- Default params, os_tick every clk, send 0xA5 with 1 stop bit, ack 3 clk after valid -> rx_data=0xA5, rx_valid high until ack+1, parity_err=frame_err=overrun=0.
- PARITY_EN=1, PARITY_ODD=0, send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, parity_err=1; rx_ack clears parity_err and rx_valid.
- 5-tick low glitch on an idle line -> START rejected, rx_valid never asserts, rx_busy returns to 0 within 9 os_ticks.
- Send 0x55 with stop bit held low for 3 bit times -> frame_err=1 with data 0x55; FSM stays in BREAK until line high; next frame 0x0F received cleanly.
- Send 0x11 then 0x22 back-to-back with no ack -> rx_data stays 0x11, overrun=1 sticky; after ack and third frame 0x33 -> rx_data=0x33, overrun still 1 until rst.
- Assert rst mid-DATA of frame 0x81 -> all outputs 0 next clk; following frame 0x7E received correctly, no stale bits.
